simon_score_display: RTL
========================

// Module: simon_score_display
// PURPOSE
//   Downstream display stage for the Simon game core. Takes the binary score
//   (0..99) produced by the game logic and converts it to two BCD digits with a
//   sequential shift-add-3 converter. Drives a 2-digit multiplexed 7-segment
//   display, with digit switching timed from the shared ticks_per_milli timebase.
// PARAMETERS
//   DIGIT_MS     4  milliseconds each digit stays lit before the mux toggles (>=1)
//   BLANK_LZ     1  1: tens digit is blanked when it is 0; 0: a leading '0' is shown
// PORTS
//   clk              in   1   system clock
//   rst              in   1   asynchronous, active-high reset
//   ticks_per_milli  in  16   clk cycles per millisecond; 0 is treated as 1
//   value            in   7   binary score; values >99 saturate to 99
//   value_load       in   1   1-cycle strobe: capture value for conversion
//   blank            in   1   1: both digit enables forced off
//   segments_invert  in   1   1: segment outputs inverted (common-anode parts)
//   segments         out  7   segment drive, bit0=a .. bit6=g, active high before invert
//   segment_digits   out  2   one-hot digit enable: 2'b01=ones, 2'b10=tens
//   busy             out  1   conversion in progress
// BEHAVIOUR
//   Reset: FSM=IDLE, pending=0, shown digits tens=0/ones=0, active digit=ones,
//     tick/ms counters=0, busy=0. Outputs after reset: segment_digits=2'b01,
//     segments=7'h3F ('0'; 7'h40 if segments_invert=1).
//   Reset asserted mid-conversion aborts it; shown digits return to 0/0.
//   FSM: IDLE, CONVERT.
//   - IDLE, value_load=1 on edge E: capture min(value,99) into shift reg, clear
//     BCD accum, go CONVERT. busy=1 from after E.
//   - CONVERT: 7 iterations, one per clk: add 3 to each BCD nibble >=5, then
//     shift {bcd,bin} left by 1. On the 7th iteration (edge E+7) the result is
//     written to the shown-digit registers and FSM returns to IDLE (busy=0 after
//     E+7). Display changes exactly 7 cycles after the load edge.
//   - value_load during CONVERT: value (saturated) stored in a 1-deep pending
//     register; a later load overwrites it (newest wins). On completion, if
//     pending is valid, FSM goes directly to CONVERT with the pending value
//     (no IDLE cycle, busy stays 1); pending is cleared.
//   - value_load on the same edge CONVERT completes: treated as a pending load.
//   Timebase: tick counter counts 0..max(ticks_per_milli,1)-1 and emits a
//     1-cycle ms pulse on wrap. A ms counter counts DIGIT_MS pulses; on the
//     DIGIT_MS-th pulse it clears and the active digit toggles ones<->tens.
//     A change of ticks_per_milli takes effect at the next wrap or whenever
//     the counter is >= the new value (counter clears).
//   Output decode (combinational from registers):
//   - digit pattern: standard hex-free 0..9 table (0=3F,1=06,2=5B,3=4F,4=66,
//     5=6D,6=7D,7=07,8=7F,9=6F); segments = pattern ^ {7{segments_invert}}.
//   - tens digit active, BLANK_LZ=1, tens==0: segments = 0 ^ invert, and
//     segment_digits = 2'b00 (no ghosting).
//   - blank=1: segment_digits=2'b00; counters and conversion keep running.
//   - segment_digits is never 2'b11.
// TESTING
//   1. Reset, ticks_per_milli=50, DIGIT_MS=4 -> digits 01, segments 7'h3F;
//      digit toggles to 10 after 200 clk, back to 01 after another 200.
//   2. value=42 load -> busy=1 for 7 cycles; 7 cycles after load edge ones
//      shows 7'h5B ('2'), tens shows 7'h66 ('4').
//   3. value=7, BLANK_LZ=1 -> tens period gives segment_digits=00; ones=7'h07.
//      value=120 -> shows 99 (7'h6F on both digits).
//   4. Load 13, then load 58 and 64 during busy -> shows 13 at +7, then 64 at
//      +14 cycles, busy high continuously across both; 58 never displayed.
//   5. segments_invert=1 with 88 -> segments 7'h00; blank=1 -> digits 00,
//      toggling resumes in phase when blank drops.
//   6. Assert rst 3 cycles into a conversion of 95 -> busy=0, digits 01,
//      segments 7'h3F; ticks_per_milli=0 -> digit toggles every DIGIT_MS clk.

Source files
------------

// File: rtl/simon_score_display.sv
// Simon score display: converts the binary score to two BCD digits (shift-add-3)
// and drives a 2-digit multiplexed 7-segment display timed from the ms timebase.
module simon_score_display #(
  parameter int DIGIT_MS = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic [6:0]  value,
  input  logic        value_load,
  input  logic        blank,
  input  logic        segments_invert,
  output logic [6:0]  segments,
  output logic [1:0]  segment_digits,
  output logic        busy
);

  localparam int MSW = (DIGIT_MS > 1) ? $clog2(DIGIT_MS) : 1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state, state_next;
  logic [6:0]  bin_q, bin_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic        pend_valid_q, pend_valid_d;
  logic [6:0]  pend_q, pend_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic [6:0]  value_sat;
  logic [7:0]  bcd_adj, bcd_shift;
  logic [6:0]  bin_shift;

  logic [15:0]    tick_cnt, tick_limit;
  logic [MSW-1:0] ms_cnt;
  logic           ms_pulse;
  logic           tens_active;

  assign value_sat = (value > 7'd99) ? 7'd99 : value;
  assign busy      = (state == CONVERT);

  // One double-dabble step: correct nibbles, then shift {bcd,bin} left
  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bcd_shift    = {bcd_adj[6:0], bin_q[6]};
    bin_shift    = {bin_q[5:0], 1'b0};
  end

  always_comb begin
    state_next   = state;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    case (state)
      IDLE: begin
        if (value_load) begin
          bin_d      = value_sat;
          bcd_d      = 8'd0;
          iter_d     = 3'd0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        bin_d  = bin_shift;
        bcd_d  = bcd_shift;
        iter_d = iter_q + 3'd1;
        if (value_load) begin
          pend_d       = value_sat;
          pend_valid_d = 1'b1;
        end
        if (iter_q == 3'd6) begin
          // Final step: publish result, chain straight into any queued value
          tens_d       = bcd_shift[7:4];
          ones_d       = bcd_shift[3:0];
          iter_d       = 3'd0;
          bcd_d        = 8'd0;
          pend_valid_d = 1'b0;
          if (value_load)        bin_d = value_sat;
          else if (pend_valid_q) bin_d = pend_q;
          else                   state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
    end else begin
      state        <= state_next;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
    end
  end

  // A counter already past a newly lowered limit wraps on the next edge
  assign tick_limit = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  assign ms_pulse   = (tick_cnt >= tick_limit - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      ms_cnt      <= '0;
      tens_active <= 1'b0;
    end else begin
      tick_cnt <= ms_pulse ? 16'd0 : tick_cnt + 16'd1;
      if (ms_pulse) begin
        if (ms_cnt == MSW'(DIGIT_MS - 1)) begin
          ms_cnt      <= '0;
          tens_active <= ~tens_active;
        end else begin
          ms_cnt <= ms_cnt + MSW'(1);
        end
      end
    end
  end

  logic [3:0] digit;
  logic [6:0] pattern;
  logic       lz_blank;

  always_comb begin
    digit    = tens_active ? tens_q : ones_q;
    lz_blank = tens_active && BLANK_LZ && (tens_q == 4'd0);
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    if (lz_blank) pattern = 7'h00;
    segments = pattern ^ {7{segments_invert}};
    if (blank || lz_blank) segment_digits = 2'b00;
    else                   segment_digits = tens_active ? 2'b10 : 2'b01;
  end

endmodule
